// File: rtl/bbc_keyboard_pkg.sv
// Shared types and constants for the BBC keyboard matrix and its PS/2 front end.
package bbc_keyboard_pkg;

  typedef struct packed {
    logic        reset_pressed;
    logic [63:0] keys_down_cols_0_to_7;
    logic [15:0] keys_down_cols_8_to_9;
  } t_bbc_keyboard;

  typedef struct packed {
    logic       valid;
    logic [3:0] column;
    logic [2:0] row;
  } t_bbc_key_loc;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_E0,
    ST_F0,
    ST_E0F0,
    ST_SKIP
  } t_kbd_state;

  localparam logic [7:0] PS2_EXTEND  = 8'hE0;
  localparam logic [7:0] PS2_RELEASE = 8'hF0;
  localparam logic [7:0] PS2_PAUSE   = 8'hE1;
  localparam logic [7:0] PS2_BAT_OK  = 8'hAA;
  localparam logic [7:0] PS2_LSHIFT  = 8'h12;
  localparam logic [7:0] PS2_RSHIFT  = 8'h59;
  localparam logic [7:0] PS2_CTRL    = 8'h14;
  localparam logic [7:0] PS2_F12     = 8'h07;

  localparam logic [2:0] SKIP_COUNT = 3'd7;

  function automatic t_bbc_key_loc key_at(input logic [3:0] column, input logic [2:0] row);
    t_bbc_key_loc loc;
    loc.valid  = 1'b1;
    loc.column = column;
    loc.row    = row;
    return loc;
  endfunction

  // Flat bit index into the 80-bit matrix: column*8 + row.
  function automatic logic [6:0] key_index(input t_bbc_key_loc loc);
    return {loc.column, loc.row};
  endfunction

endpackage

// File: rtl/bbc_ps2_key_map.sv
// Combinational translation of a PS/2 set-2 key ({extended, code}) to a BBC matrix location.
module bbc_ps2_key_map
  import bbc_keyboard_pkg::*;
(
  input  logic         ext,
  input  logic [7:0]   code,
  output t_bbc_key_loc loc,
  output logic         is_break_key
);

  always_comb begin
    loc          = '0;
    is_break_key = (!ext) && (code == PS2_F12);
    // Shift and Ctrl are kept as shadows in the top level, so row 0 is never produced here.
    case ({ext, code})
      // row 1
      9'h015: loc = key_at(4'd0, 3'd1);  // Q
      9'h026: loc = key_at(4'd1, 3'd1);  // 3
      9'h025: loc = key_at(4'd2, 3'd1);  // 4
      9'h02E: loc = key_at(4'd3, 3'd1);  // 5
      9'h00C: loc = key_at(4'd4, 3'd1);  // F4 -> f4
      9'h03E: loc = key_at(4'd5, 3'd1);  // 8
      9'h083: loc = key_at(4'd6, 3'd1);  // F7 -> f7
      9'h04E: loc = key_at(4'd7, 3'd1);  // -
      9'h055: loc = key_at(4'd8, 3'd1);  // = -> ^
      9'h16B: loc = key_at(4'd9, 3'd1);  // Left
      // row 2
      9'h009: loc = key_at(4'd0, 3'd2);  // F10 -> f0
      9'h01D: loc = key_at(4'd1, 3'd2);  // W
      9'h024: loc = key_at(4'd2, 3'd2);  // E
      9'h02C: loc = key_at(4'd3, 3'd2);  // T
      9'h03D: loc = key_at(4'd4, 3'd2);  // 7
      9'h043: loc = key_at(4'd5, 3'd2);  // I
      9'h046: loc = key_at(4'd6, 3'd2);  // 9
      9'h045: loc = key_at(4'd7, 3'd2);  // 0
      9'h00E: loc = key_at(4'd8, 3'd2);  // ` -> _
      9'h172: loc = key_at(4'd9, 3'd2);  // Down
      // row 3
      9'h016: loc = key_at(4'd0, 3'd3);  // 1
      9'h01E: loc = key_at(4'd1, 3'd3);  // 2
      9'h023: loc = key_at(4'd2, 3'd3);  // D
      9'h02D: loc = key_at(4'd3, 3'd3);  // R
      9'h036: loc = key_at(4'd4, 3'd3);  // 6
      9'h03C: loc = key_at(4'd5, 3'd3);  // U
      9'h044: loc = key_at(4'd6, 3'd3);  // O
      9'h04D: loc = key_at(4'd7, 3'd3);  // P
      9'h054: loc = key_at(4'd8, 3'd3);  // [
      9'h175: loc = key_at(4'd9, 3'd3);  // Up
      // row 4
      9'h058: loc = key_at(4'd0, 3'd4);  // Caps Lock
      9'h01C: loc = key_at(4'd1, 3'd4);  // A
      9'h022: loc = key_at(4'd2, 3'd4);  // X
      9'h02B: loc = key_at(4'd3, 3'd4);  // F
      9'h035: loc = key_at(4'd4, 3'd4);  // Y
      9'h03B: loc = key_at(4'd5, 3'd4);  // J
      9'h042: loc = key_at(4'd6, 3'd4);  // K
      9'h171: loc = key_at(4'd7, 3'd4);  // Delete -> @
      9'h052: loc = key_at(4'd8, 3'd4);  // ' -> :
      9'h05A: loc = key_at(4'd9, 3'd4);  // Return
      // row 5
      9'h011: loc = key_at(4'd0, 3'd5);  // Left Alt -> Shift Lock
      9'h01B: loc = key_at(4'd1, 3'd5);  // S
      9'h021: loc = key_at(4'd2, 3'd5);  // C
      9'h034: loc = key_at(4'd3, 3'd5);  // G
      9'h033: loc = key_at(4'd4, 3'd5);  // H
      9'h031: loc = key_at(4'd5, 3'd5);  // N
      9'h04B: loc = key_at(4'd6, 3'd5);  // L
      9'h04C: loc = key_at(4'd7, 3'd5);  // ;
      9'h05B: loc = key_at(4'd8, 3'd5);  // ]
      9'h066: loc = key_at(4'd9, 3'd5);  // Backspace -> Delete
      // row 6
      9'h00D: loc = key_at(4'd0, 3'd6);  // Tab
      9'h01A: loc = key_at(4'd1, 3'd6);  // Z
      9'h029: loc = key_at(4'd2, 3'd6);  // Space
      9'h02A: loc = key_at(4'd3, 3'd6);  // V
      9'h032: loc = key_at(4'd4, 3'd6);  // B
      9'h03A: loc = key_at(4'd5, 3'd6);  // M
      9'h041: loc = key_at(4'd6, 3'd6);  // ,
      9'h049: loc = key_at(4'd7, 3'd6);  // .
      9'h04A: loc = key_at(4'd8, 3'd6);  // /
      9'h169: loc = key_at(4'd9, 3'd6);  // End -> Copy
      // row 7
      9'h076: loc = key_at(4'd0, 3'd7);  // Esc
      9'h005: loc = key_at(4'd1, 3'd7);  // F1 -> f1
      9'h006: loc = key_at(4'd2, 3'd7);  // F2 -> f2
      9'h004: loc = key_at(4'd3, 3'd7);  // F3 -> f3
      9'h003: loc = key_at(4'd4, 3'd7);  // F5 -> f5
      9'h00B: loc = key_at(4'd5, 3'd7);  // F6 -> f6
      9'h00A: loc = key_at(4'd6, 3'd7);  // F8 -> f8
      9'h001: loc = key_at(4'd7, 3'd7);  // F9 -> f9
      9'h05D: loc = key_at(4'd8, 3'd7);  // backslash
      9'h174: loc = key_at(4'd9, 3'd7);  // Right
      default: loc = '0;
    endcase
  end

endmodule

// File: rtl/bbc_ps2_keyboard_matrix.sv
// PS/2 set-2 scancode decoder maintaining the BBC 10x8 key matrix plus the Break key line.
module bbc_ps2_keyboard_matrix
  import bbc_keyboard_pkg::*;
#(
  parameter logic [7:0] DIP_SWITCHES = 8'h00
) (
  input  logic        clk,
  input  logic        clk__enable,
  input  logic        reset,
  input  logic        ps2_key__valid,
  input  logic [7:0]  ps2_key__data,
  input  logic        ps2_key__error,
  output logic        bbc_keyboard__reset_pressed,
  output logic [63:0] bbc_keyboard__keys_down_cols_0_to_7,
  output logic [15:0] bbc_keyboard__keys_down_cols_8_to_9
);

  t_kbd_state   state_q, state_d;
  logic [2:0]   skip_q, skip_d;
  logic [79:0]  matrix_q, matrix_d;
  logic         lshift_q, lshift_d;
  logic         rshift_q, rshift_d;
  logic         lctrl_q, lctrl_d;
  logic         rctrl_q, rctrl_d;
  logic         reset_pressed_q, reset_pressed_d;

  logic         map_ext;
  t_bbc_key_loc map_loc;
  logic         map_is_break_key;
  logic         do_make;
  logic         do_break;
  logic         key_level;
  logic         is_fake_shift;

  t_bbc_keyboard kbd;
  logic [79:0]   keys_all;

  assign map_ext       = (state_q == ST_E0) || (state_q == ST_E0F0);
  assign is_fake_shift = (ps2_key__data == PS2_LSHIFT) || (ps2_key__data == PS2_RSHIFT);

  bbc_ps2_key_map u_key_map (
    .ext          (map_ext),
    .code         (ps2_key__data),
    .loc          (map_loc),
    .is_break_key (map_is_break_key)
  );

  always_comb begin
    state_d         = state_q;
    skip_d          = skip_q;
    matrix_d        = matrix_q;
    lshift_d        = lshift_q;
    rshift_d        = rshift_q;
    lctrl_d         = lctrl_q;
    rctrl_d         = rctrl_q;
    reset_pressed_d = reset_pressed_q;
    do_make         = 1'b0;
    do_break        = 1'b0;
    key_level       = 1'b0;

    if (clk__enable) begin
      if (ps2_key__error) begin
        state_d = ST_IDLE;
        skip_d  = '0;
      end else if (ps2_key__valid) begin
        case (state_q)
          ST_IDLE: begin
            case (ps2_key__data)
              PS2_EXTEND:  state_d = ST_E0;
              PS2_RELEASE: state_d = ST_F0;
              PS2_PAUSE: begin
                state_d = ST_SKIP;
                skip_d  = SKIP_COUNT;
              end
              PS2_BAT_OK: begin
                // Keyboard self-test completion: forget everything that was held.
                matrix_d        = '0;
                lshift_d        = 1'b0;
                rshift_d        = 1'b0;
                lctrl_d         = 1'b0;
                rctrl_d         = 1'b0;
                reset_pressed_d = 1'b0;
              end
              8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
              default: do_make = 1'b1;
            endcase
          end
          ST_E0: begin
            if (ps2_key__data == PS2_RELEASE) begin
              state_d = ST_E0F0;
            end else begin
              state_d = ST_IDLE;
              do_make = !is_fake_shift;
            end
          end
          ST_F0: begin
            state_d  = ST_IDLE;
            do_break = 1'b1;
          end
          ST_E0F0: begin
            state_d  = ST_IDLE;
            do_break = !is_fake_shift;
          end
          ST_SKIP: begin
            skip_d = skip_q - 3'd1;
            if (skip_q <= 3'd1) begin
              state_d = ST_IDLE;
              skip_d  = '0;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    if (do_make || do_break) begin
      key_level = do_make;
      if (!map_ext && ps2_key__data == PS2_LSHIFT) lshift_d = key_level;
      if (!map_ext && ps2_key__data == PS2_RSHIFT) rshift_d = key_level;
      if (!map_ext && ps2_key__data == PS2_CTRL)   lctrl_d  = key_level;
      if (map_ext && ps2_key__data == PS2_CTRL)    rctrl_d  = key_level;
      if (map_is_break_key)                        reset_pressed_d = key_level;
      if (map_loc.valid)                           matrix_d[key_index(map_loc)] = key_level;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      skip_q          <= '0;
      matrix_q        <= '0;
      lshift_q        <= 1'b0;
      rshift_q        <= 1'b0;
      lctrl_q         <= 1'b0;
      rctrl_q         <= 1'b0;
      reset_pressed_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      skip_q          <= skip_d;
      matrix_q        <= matrix_d;
      lshift_q        <= lshift_d;
      rshift_q        <= rshift_d;
      lctrl_q         <= lctrl_d;
      rctrl_q         <= rctrl_d;
      reset_pressed_q <= reset_pressed_d;
    end
  end

  // Row 0 of columns 2..9 carries the DIP switches; columns 0/1 carry the merged shift/ctrl pairs.
  always_comb begin
    keys_all    = matrix_q;
    keys_all[0] = matrix_q[0] | lshift_q | rshift_q;
    keys_all[8] = matrix_q[8] | lctrl_q | rctrl_q;
    for (int i = 0; i < 8; i++) begin
      keys_all[(i + 2) * 8] = matrix_q[(i + 2) * 8] | DIP_SWITCHES[i];
    end
  end

  always_comb begin
    kbd.reset_pressed         = reset_pressed_q;
    kbd.keys_down_cols_0_to_7 = keys_all[63:0];
    kbd.keys_down_cols_8_to_9 = keys_all[79:64];
  end

  assign bbc_keyboard__reset_pressed         = kbd.reset_pressed;
  assign bbc_keyboard__keys_down_cols_0_to_7 = kbd.keys_down_cols_0_to_7;
  assign bbc_keyboard__keys_down_cols_8_to_9 = kbd.keys_down_cols_8_to_9;

endmodule

// File: tb/tb_bbc_ps2_keyboard_matrix.sv
// Directed scancode sequences with a scoreboard queue of expected key-matrix snapshots.
module tb_bbc_ps2_keyboard_matrix;

  logic        clk = 1'b0;
  logic        clk__enable = 1'b1;
  logic        reset = 1'b1;
  logic        ps2_key__valid = 1'b0;
  logic [7:0]  ps2_key__data = 8'h00;
  logic        ps2_key__error = 1'b0;
  logic        rp;
  logic [63:0] c07;
  logic [15:0] c89;

  localparam logic [63:0] D07 = 64'h0000_0000_0001_0000;
  localparam logic [15:0] D89 = 16'h0100;

  typedef struct packed {
    logic        rp;
    logic [63:0] c07;
    logic [15:0] c89;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  logic  chk_req = 1'b0;
  int    n_vec = 0;
  int    n_err = 0;

  bbc_ps2_keyboard_matrix #(.DIP_SWITCHES(8'h81)) dut (
    .clk                                 (clk),
    .clk__enable                         (clk__enable),
    .reset                               (reset),
    .ps2_key__valid                      (ps2_key__valid),
    .ps2_key__data                       (ps2_key__data),
    .ps2_key__error                      (ps2_key__error),
    .bbc_keyboard__reset_pressed         (rp),
    .bbc_keyboard__keys_down_cols_0_to_7 (c07),
    .bbc_keyboard__keys_down_cols_8_to_9 (c89)
  );

  always #5 clk = ~clk;

  // Monitor: pops one expected snapshot per check request and compares after the edge.
  always @(posedge clk) begin
    if (chk_req) begin
      #1;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_underflow: no expected entry queued");
      end else begin
        exp_t  e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_vec++;
        if (rp !== e.rp || c07 !== e.c07 || c89 !== e.c89)
        begin
          n_err++;
          $display("FAIL %s: got rp=%0b c07=%h c89=%h, expected rp=%0b c07=%h c89=%h",
                   nm, rp, c07, c89, e.rp, e.c07, e.c89);
        end else begin
          $display("ok   %s: rp=%0b c07=%h c89=%h", nm, rp, c07, c89);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    ps2_key__valid = 1'b1;
    ps2_key__data  = b;
    @(negedge clk);
    ps2_key__valid = 1'b0;
  endtask

  task automatic send_err(input logic [7:0] b);
    @(negedge clk);
    ps2_key__valid = 1'b1;
    ps2_key__error = 1'b1;
    ps2_key__data  = b;
    @(negedge clk);
    ps2_key__valid = 1'b0;
    ps2_key__error = 1'b0;
  endtask

  task automatic expect_state(input string nm, input logic e_rp,
                              input logic [63:0] e_c07, input logic [15:0] e_c89);
    exp_t e;
    e.rp  = e_rp;
    e.c07 = e_c07;
    e.c89 = e_c89;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    chk_req = 1'b1;
    @(negedge clk);
    chk_req = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    expect_state("reset_dip", 1'b0, D07, D89);

    send(8'h1C);
    expect_state("make_A", 1'b0, D07 | (64'd1 << 12), D89);
    send(8'hF0); send(8'h1C);
    expect_state("break_A", 1'b0, D07, D89);

    send(8'hE0); send(8'h75);
    expect_state("make_up", 1'b0, D07, D89 | (16'd1 << 11));
    send(8'hE0); send(8'hF0); send(8'h75);
    expect_state("break_up", 1'b0, D07, D89);
    send(8'hE0); send(8'h12); send(8'hE0); send(8'h75);
    expect_state("fake_shift_up", 1'b0, D07, D89 | (16'd1 << 11));
    send(8'hE0); send(8'hF0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h12);
    expect_state("fake_shift_release", 1'b0, D07, D89);

    send(8'h12); send(8'h59); send(8'hF0); send(8'h12);
    expect_state("shift_pair_hold", 1'b0, D07 | 64'd1, D89);
    send(8'hF0); send(8'h59);
    expect_state("shift_pair_release", 1'b0, D07, D89);
    send(8'h14); send(8'hE0); send(8'h14); send(8'hF0); send(8'h14);
    expect_state("ctrl_pair_hold", 1'b0, D07 | (64'd1 << 8), D89);
    send(8'hE0); send(8'hF0); send(8'h14);
    expect_state("ctrl_pair_release", 1'b0, D07, D89);

    send(8'h05); send(8'h09); send(8'h5A); send(8'h66);
    expect_state("f1_f10_ret_del", 1'b0, D07 | (64'd1 << 15) | (64'd1 << 2),
                 D89 | (16'd1 << 12) | (16'd1 << 13));
    send(8'hF0); send(8'h05); send(8'hF0); send(8'h09);
    send(8'hF0); send(8'h5A); send(8'hF0); send(8'h66);
    expect_state("fkeys_released", 1'b0, D07, D89);

    send(8'h1C); send(8'hF0); send_err(8'h1C); send(8'h29);
    expect_state("err_drops_prefix", 1'b0, D07 | (64'd1 << 12) | (64'd1 << 22), D89);
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h29);
    expect_state("err_cleanup", 1'b0, D07, D89);

    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h76);
    expect_state("pause_skipped_esc", 1'b0, D07 | (64'd1 << 7), D89);
    send(8'hF0); send(8'h76);
    expect_state("esc_released", 1'b0, D07, D89);

    send(8'h07);
    expect_state("f12_break_held", 1'b1, D07, D89);
    send(8'h1C); send(8'h12);
    send(8'hAA);
    expect_state("bat_clears", 1'b0, D07, D89);
    send(8'h59); send(8'hF0); send(8'h59);
    expect_state("bat_cleared_shadow", 1'b0, D07, D89);

    send(8'hE0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    send(8'h75);
    expect_state("reset_drops_e0", 1'b0, D07, D89);

    @(negedge clk);
    clk__enable    = 1'b0;
    ps2_key__valid = 1'b1;
    ps2_key__data  = 8'h1C;
    repeat (3) @(negedge clk);
    ps2_key__valid = 1'b0;
    clk__enable    = 1'b1;
    expect_state("enable_low_holds", 1'b0, D07, D89);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: %0d entries unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
